// File: rtl/elbeth_mem_access.sv
// Load/store initiator for one port of the ELBETH data memory: byte/half/word
// requests become word address + byte strobes, with aligned, extended load data.
module elbeth_mem_access #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_error,
  output logic          dmem_enable,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_data_in,
  output logic [3:0]    dmem_wr,
  input  logic [31:0]   dmem_data_out,
  input  logic          dmem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  function automatic logic req_legal(input logic [1:0] size, input logic [31:0] addr);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr[0];
      2'b10:   ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok && ((addr >> (AW + 2)) == 32'd0);
  endfunction

  function automatic logic [3:0] strobes(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_format(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [7:0]      cnt_r, cnt_s;
  logic            we_r, we_s;
  logic [1:0]      size_r, size_s;
  logic            uns_r, uns_s;
  logic [1:0]      off_r, off_s;
  logic            resp_valid_r, resp_valid_s;
  logic            resp_error_r, resp_error_s;
  logic [31:0]     resp_rdata_r, resp_rdata_s;
  logic            en_r, en_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic [31:0]     din_r, din_s;
  logic [3:0]      wr_r, wr_s;

  // Next-state and next-output computation; pulses default low every cycle
  always_comb begin
    state_s      = state_r;
    cnt_s        = 8'd0;
    we_s         = we_r;
    size_s       = size_r;
    uns_s        = uns_r;
    off_s        = off_r;
    resp_valid_s = 1'b0;
    resp_error_s = 1'b0;
    resp_rdata_s = 32'd0;
    en_s         = 1'b0;
    addr_s       = addr_r;
    din_s        = din_r;
    wr_s         = 4'b0000;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          we_s   = req_we;
          size_s = req_size;
          uns_s  = req_unsigned;
          off_s  = req_addr[1:0];
          if (req_legal(req_size, req_addr)) begin
            state_s = ACCESS;
            en_s    = 1'b1;
            addr_s  = req_addr[AW+1:2];
            din_s   = lanes(req_size, req_wdata);
            wr_s    = req_we ? strobes(req_size, req_addr[1:0]) : 4'b0000;
          end else begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: state_s = WAIT;
      WAIT: begin
        if (dmem_ready) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = we_r ? 32'd0 : load_format(size_r, uns_r, off_r, dmem_data_out);
        end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_error_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      off_r        <= 2'b00;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      en_r         <= 1'b0;
      addr_r       <= '0;
      din_r        <= 32'd0;
      wr_r         <= 4'b0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      we_r         <= we_s;
      size_r       <= size_s;
      uns_r        <= uns_s;
      off_r        <= off_s;
      resp_valid_r <= resp_valid_s;
      resp_error_r <= resp_error_s;
      resp_rdata_r <= resp_rdata_s;
      en_r         <= en_s;
      addr_r       <= addr_s;
      din_r        <= din_s;
      wr_r         <= wr_s;
    end
  end

  assign req_ready    = (state_r == IDLE) && rst;
  assign resp_valid   = resp_valid_r;
  assign resp_error   = resp_error_r;
  assign resp_rdata   = resp_rdata_r;
  assign dmem_enable  = en_r;
  assign dmem_addr    = addr_r;
  assign dmem_data_in = din_r;
  assign dmem_wr      = wr_r;

endmodule

// File: tb/tb_elbeth_mem_access.sv
// Directed bench for elbeth_mem_access with a registered byte-writable memory model.
module tb_elbeth_mem_access;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_error;
  logic [31:0]   resp_rdata;
  logic          dmem_enable, dmem_ready;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_data_in, dmem_data_out;
  logic [3:0]    dmem_wr;

  elbeth_mem_access #(.AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .dmem_enable(dmem_enable), .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in),
    .dmem_wr(dmem_wr), .dmem_data_out(dmem_data_out), .dmem_ready(dmem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: ready and read data registered one cycle after enable
  logic [31:0] mem [0:255];
  logic [31:0] rd_q;
  logic        stall;
  always @(posedge clk) begin
    if (dmem_enable && !stall) begin
      rd_q       <= mem[dmem_addr];
      dmem_ready <= 1'b1;
      for (int b = 0; b < 4; b++)
        if (dmem_wr[b]) mem[dmem_addr][8*b +: 8] <= dmem_data_in[8*b +: 8];
    end else begin
      dmem_ready <= 1'b0;
    end
  end
  assign dmem_data_out = dmem_ready ? rd_q : 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   r_rdata, r_din;
  logic          r_err, r_valid, r_bad_strobe;
  logic [3:0]    r_wr;
  logic [AW-1:0] r_addr;
  int            r_lat, r_en_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then sample #1 after each edge until the response or budget expires
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 1; r_en_cnt = 0; r_bad_strobe = 1'b0;
    r_wr = 4'b0000; r_addr = '0; r_din = 32'd0;
    while (1) begin
      if (dmem_enable) begin
        r_en_cnt++;
        r_wr = dmem_wr; r_addr = dmem_addr; r_din = dmem_data_in;
      end
      if (!dmem_enable && dmem_wr != 4'b0000) r_bad_strobe = 1'b1;
      if (resp_valid || r_lat >= 40) break;
      @(posedge clk);
      #1 r_lat++;
    end
    r_valid = resp_valid; r_rdata = resp_rdata; r_err = resp_error;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;
    mem[8] = 32'h11223344;
    stall = 1'b0; dmem_ready = 1'b0; rd_q = 32'd0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_enable", {31'd0, dmem_enable}, 32'd0);
    check("rst_wr", {28'd0, dmem_wr}, 32'd0);
    check("rst_addr", {24'd0, dmem_addr}, 32'd0);
    check("rst_din", dmem_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    access(1'b0, 2'b00, 1'b0, 32'h11, 32'd0);
    check("lb_11", r_rdata, 32'hFFFFFFAA);
    check("lb_lat", r_lat, 32'd3);
    check("lb_err", {31'd0, r_err}, 32'd0);
    check("lb_en_cnt", r_en_cnt, 32'd1);
    check("lb_wr", {28'd0, r_wr}, 32'd0);
    check("lb_addr", {24'd0, r_addr}, 32'h04);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    check("lbu_13", r_rdata, 32'h00000088);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    check("lh_12", r_rdata, 32'hFFFF8899);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
    check("lhu_10", r_rdata, 32'h0000AABB);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check("lw_10", r_rdata, 32'h8899AABB);

    access(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456CD);
    check("sb_wr", {28'd0, r_wr}, 32'b0010);
    check("sb_addr", {24'd0, r_addr}, 32'h08);
    check("sb_din", r_din, 32'hCDCDCDCD);
    check("sb_rdata", r_rdata, 32'd0);
    check("sb_lat", r_lat, 32'd3);
    check("sb_strobe_no_en", {31'd0, r_bad_strobe}, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    check("lw_20_after_sb", r_rdata, 32'h1122CD44);
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    check("sh_wr", {28'd0, r_wr}, 32'b1100);
    check("sh_din", r_din, 32'hBEEFBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    check("lw_20_after_sh", r_rdata, 32'hBEEFCD44);

    access(1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
    check("mis_lat", r_lat, 32'd1);
    check("mis_err", {31'd0, r_err}, 32'd1);
    check("mis_rdata", r_rdata, 32'd0);
    check("mis_en_cnt", r_en_cnt, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    check("oor_lat", r_lat, 32'd1);
    check("oor_err", {31'd0, r_err}, 32'd1);
    check("oor_en_cnt", r_en_cnt, 32'd0);
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'h55);
    check("size11_err", {31'd0, r_err}, 32'd1);
    check("size11_en_cnt", r_en_cnt, 32'd0);

    stall = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check("to_valid", {31'd0, r_valid}, 32'd1);
    check("to_err", {31'd0, r_err}, 32'd1);
    check("to_wait_cycles", r_lat - 2, 32'd15);
    check("to_rdata", r_rdata, 32'd0);
    stall = 1'b0;
    @(posedge clk);
    #1 check("to_back_idle", {31'd0, req_ready}, 32'd1);

    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("wrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("wrst_rdata", resp_rdata, 32'd0);
    check("wrst_enable", {31'd0, dmem_enable}, 32'd0);
    check("wrst_addr", {24'd0, dmem_addr}, 32'd0);
    check("wrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("wrst_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("wrst_ready_again", {31'd0, req_ready}, 32'd1);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check("post_rst_lw", r_rdata, 32'h8899AABB);
    check("post_rst_lat", r_lat, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
